// File: rtl/matrix_gen_bram.sv
// Pattern-fill memory: on start, writes a ROWS x COLS matrix pattern into a 2**AW x DW RAM, one entry per cycle.
// Optional MATGEN_AUTOSTART_EN: launch a ramp fill (mode 0, seed 0) on the first clock after reset release.
module matrix_gen_bram #(
  parameter int DW   = 32,
  parameter int AW   = 8,
  parameter int ROWS = 2,
  parameter int COLS = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [1:0]    mode,
  input  logic [DW-1:0] seed,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          busy,
  output logic          wr_done
);

  localparam int N     = ROWS * COLS;
  localparam int DEPTH = 2 ** AW;

  if (N > DEPTH || N == 0) begin : g_bad_geometry
    $error("matrix_gen_bram: ROWS*COLS=%0d must be in 1..2**AW=%0d", N, DEPTH);
  end

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_addr, w_addr_nxt;
  logic [AW-1:0] r_row, w_row_nxt;
  logic [AW-1:0] r_col, w_col_nxt;
  logic [1:0]    r_mode, w_mode_nxt;
  logic [DW-1:0] r_seed, w_seed_nxt;
  logic          w_auto;
  logic          w_go;
  logic          w_wr_en;
  logic [DW-1:0] w_wr_data;
  logic          w_in_range;
  logic [DW-1:0] r_mem [DEPTH];

  function automatic logic [DW-1:0] f_pattern(input logic [1:0]    m,
                                              input logic [DW-1:0] s,
                                              input logic [AW-1:0] k,
                                              input logic [AW-1:0] r,
                                              input logic [AW-1:0] c);
    logic [DW-1:0] v;
    case (m)
      2'd0:    v = s + DW'(k);
      2'd1:    v = s;
      2'd2:    v = (r == c) ? s : '0;
      default: v = s + DW'(c) * DW'(ROWS) + DW'(r);
    endcase
    return v;
  endfunction

`ifdef MATGEN_AUTOSTART_EN
  logic r_auto;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_auto <= 1'b1;
    else        r_auto <= 1'b0;
  end
  assign w_auto = r_auto;
`else
  assign w_auto = 1'b0;
`endif

  assign w_go      = start | w_auto;
  assign w_wr_data = f_pattern(r_mode, r_seed, r_addr, r_row, r_col);

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_row_nxt   = r_row;
    w_col_nxt   = r_col;
    w_mode_nxt  = r_mode;
    w_seed_nxt  = r_seed;
    w_wr_en     = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (w_go) begin
          w_state_nxt = FILL;
          w_addr_nxt  = '0;
          w_row_nxt   = '0;
          w_col_nxt   = '0;
          // An explicit start takes precedence over the autostart defaults
          w_mode_nxt  = start ? mode : 2'd0;
          w_seed_nxt  = start ? seed : '0;
        end
      end
      FILL: begin
        w_wr_en = 1'b1;
        if (r_addr == AW'(N - 1)) begin
          w_state_nxt = DONE;
        end else begin
          w_addr_nxt = r_addr + 1'b1;
          if (r_col == AW'(COLS - 1)) begin
            w_col_nxt = '0;
            w_row_nxt = r_row + 1'b1;
          end else begin
            w_col_nxt = r_col + 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_row   <= '0;
      r_col   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_row   <= w_row_nxt;
      r_col   <= w_col_nxt;
    end
  end

  // Pattern configuration is captured only at fill launch and needs no reset
  always_ff @(posedge clk) begin
    r_mode <= w_mode_nxt;
    r_seed <= w_seed_nxt;
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_addr] <= w_wr_data;
  end

  assign w_in_range = ({1'b0, rd_addr} < (AW + 1)'(N));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= w_in_range ? r_mem[rd_addr] : '0;
    end
  end

  assign busy    = (r_state == FILL);
  assign wr_done = (r_state == DONE);

endmodule

// File: doc/matrix_gen_bram.md
MATRIX_GEN_BRAM -- requirements
Module: matrix_gen_bram

Interface
REQ-001 The block SHALL have parameter DW, default 32, meaning data word width in bits.
REQ-002 The block SHALL have parameter AW, default 8, meaning address width; memory depth is 2**AW words.
REQ-003 The block SHALL have parameter ROWS, default 2, meaning number of matrix rows.
REQ-004 The block SHALL have parameter COLS, default 4, meaning number of matrix columns.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL be on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit, asynchronous active-low reset.
REQ-007 The block SHALL have port start, input, 1 bit, a one-cycle pulse that requests a fill.
REQ-008 The block SHALL have port mode, input, 2 bits, the fill pattern select, sampled on an accepted start.
REQ-009 The block SHALL have port seed, input, DW bits, the pattern seed, sampled on an accepted start.
REQ-010 The block SHALL have port rd_en, input, 1 bit, the read request.
REQ-011 The block SHALL have port rd_addr, input, AW bits, the read address.
REQ-012 The block SHALL have port rd_data, output, DW bits, the read data.
REQ-013 The block SHALL have port rd_valid, output, 1 bit, which marks rd_data as valid.
REQ-014 The block SHALL have port busy, output, 1 bit, high while a fill is in progress.
REQ-015 The block SHALL have port wr_done, output, 1 bit, high once a fill has completed.

Function
REQ-016 The block SHALL hold a 2**AW x DW memory with one internal write port and one external read port.
REQ-017 The block SHALL implement states IDLE, FILL and DONE: start in IDLE or DONE -> FILL; last entry written -> DONE.
REQ-018 In FILL, the block SHALL write exactly one entry per cycle at addresses 0..ROWS*COLS-1 in ascending order, so a fill takes ROWS*COLS cycles.
REQ-019 For entry k, the block SHALL use row r = k / COLS and column c = k % COLS.
REQ-020 Mode 0 (ramp) SHALL write seed + k, modulo 2**DW.
REQ-021 Mode 1 (constant) SHALL write seed.
REQ-022 Mode 2 (identity) SHALL write seed when r == c and 0 otherwise.
REQ-023 Mode 3 (transpose ramp) SHALL write seed + c*ROWS + r, modulo 2**DW.
REQ-024 busy SHALL be 1 exactly in FILL.
REQ-025 wr_done SHALL go to 1 in the cycle after the last write and stay at 1 until the next accepted start or reset.
REQ-026 start during FILL SHALL be ignored; mode and seed changes during FILL SHALL have no effect.
REQ-027 start in DONE SHALL clear wr_done on the next edge and restart the fill from address 0.
REQ-028 Reads SHALL have a latency of 1 cycle: rd_valid(t+1) = rd_en(t), and rd_data updates only when rd_en = 1.
REQ-029 A read with rd_addr >= ROWS*COLS SHALL return 0 with rd_valid = 1.
REQ-030 A read to the address being written in the same cycle SHALL return the old contents.
REQ-031 Reads SHALL be allowed in every state.
REQ-032 Memory contents beyond ROWS*COLS SHALL never be written.

Reset
REQ-033 reset low SHALL immediately force state IDLE, fill address 0, busy 0, wr_done 0, rd_valid 0 and rd_data 0.
REQ-034 Memory contents SHALL NOT be cleared by reset.
REQ-035 A reset asserted mid-FILL SHALL abort the fill; entries already written SHALL keep their values.
REQ-036 After reset deasserts, the block SHALL stay in IDLE until start, unless REQ-038 applies.

Configuration
REQ-037 Macro MATGEN_AUTOSTART_EN SHALL select the start-up behaviour.
REQ-038 With MATGEN_AUTOSTART_EN defined, the block SHALL enter FILL on the first clock after reset deasserts, using mode 0 and seed 0.
REQ-039 Without MATGEN_AUTOSTART_EN, a fill SHALL begin only on start.
REQ-040 Elaboration SHALL fail if ROWS*COLS > 2**AW or ROWS*COLS == 0.

Verification
REQ-041 Ramp: ROWS=2, COLS=4, start with mode 0, seed 0x10 -> busy for 8 cycles, then wr_done=1; reads of addresses 0..7 return 0x10..0x17.
REQ-042 Identity and transpose: ROWS=3, COLS=3, mode 2, seed 5 -> addresses 0, 4 and 8 read 5 and all others read 0; mode 3, seed 0 -> address 1 reads 3 and address 3 reads 1.
REQ-043 Wrap and bounds: DW=8, mode 0, seed 0xFE -> address 2 reads 0x00; a read of address 8 with the default geometry returns 0.
REQ-044 Abort: reset pulled low at fill cycle 3, then a new start with mode 1, seed 0xA -> busy and wr_done drop immediately, and the refill writes 0xA to all 8 entries.
REQ-045 Collisions: start during FILL is ignored (the done time is unchanged); a read of address k in the cycle it is written returns the previous fill's value.
REQ-046 Autostart: with MATGEN_AUTOSTART_EN defined, after reset release with no start -> wr_done=1 after 8 cycles and address 5 reads 5.
